conv2_dw: RTL and testbench

- Streaming 3x3 depthwise convolution stage (stride 1, no padding), 8 channels of 8-bit activations.
- Sits directly upstream of the conv2 pointwise stage. Its valid/64-bit output drives that stage's valid/input_act with no backpressure.
- Consumes a raster-order pixel stream and keeps two line buffers plus a 3x3 window per channel.
- Per channel: fixed-weight MAC, bias add and clamped ReLU requantization.

---
 rtl/conv2_dw.sv | 179 +++++++++++++++++
 tb/tb_conv2_dw.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_dw.sv
// conv2_dw: streaming 3x3 depthwise convolution (stride 1, no padding) over
// a raster-order pixel stream of NCH 8-bit channels. Three-stage pipeline:
// stage 0 registers the pixel and its position, stage 1 updates the line
// buffers and the 3x3 window, stage 2 registers the MAC/ReLU result.
module conv2_dw #(
    parameter int                      IMG_W   = 8,
    parameter int                      IMG_H   = 8,
    parameter int                      NCH     = 8,
    parameter logic [NCH*9*8-1:0]      W_DW    = {(NCH*9){8'h10}},
    parameter logic [NCH*8-1:0]        B_DW    = {NCH{8'h00}},
    parameter int                      ACT_MAX = 127
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 valid,
    input  logic                 sof,
    input  logic [NCH*8-1:0]     input_act,
    output logic [NCH*8-1:0]     output_act,
    output logic                 ready
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = NCH * 8;

    // 9-tap signed MAC with the bias zero-extended into the accumulator.
    function automatic logic signed [31:0] mac9(input logic [71:0] wts,
                                                input logic [71:0] pix,
                                                input logic [7:0]  bias);
        logic signed [31:0] acc;
        logic signed [7:0]  a;
        logic signed [7:0]  b;
        acc = 32'(bias);
        for (int t = 0; t < 9; t++) begin
            a   = wts[t*8 +: 8];
            b   = pix[t*8 +: 8];
            acc = acc + (32'(a) * 32'(b));
        end
        return acc;
    endfunction

    // Clamped ReLU requantization: negative -> 0, else (sum >> 7) capped.
    function automatic logic [7:0] requant(input logic signed [31:0] s);
        logic [7:0] q;
        if (s[31]) begin
            q = 8'h00;
        end else if (s[31:7] > 25'(ACT_MAX)) begin
            q = 8'(ACT_MAX);
        end else begin
            q = s[14:7];
        end
        return q;
    endfunction

    // Stage 0 / position counter state
    logic [CW-1:0] r_cnt_col;
    logic [RW-1:0] r_cnt_row;
    logic          r_v0;
    logic [PW-1:0] r_px0;
    logic [CW-1:0] r_col0;
    logic [RW-1:0] r_row0;

    // Stage 1 state
    logic [PW-1:0] r_lb0 [IMG_W];
    logic [PW-1:0] r_lb1 [IMG_W];
    logic [PW-1:0] r_win [3][3];
    logic          r_emit1;

    // Combinational helpers
    logic [CW-1:0] w_pos_col;
    logic [RW-1:0] w_pos_row;
    logic [CW-1:0] w_nxt_col;
    logic [RW-1:0] w_nxt_row;
    logic [71:0]   w_taps [NCH];
    logic [PW-1:0] w_q;

    // Position of the incoming pixel (sof forces 0,0) and the counter successor.
    always_comb begin
        w_pos_col = r_cnt_col;
        w_pos_row = r_cnt_row;
        w_nxt_col = r_cnt_col;
        w_nxt_row = r_cnt_row;
        if (sof) begin
            w_pos_col = {CW{1'b0}};
            w_pos_row = {RW{1'b0}};
        end else begin
            w_pos_col = r_cnt_col;
            w_pos_row = r_cnt_row;
        end
        if (w_pos_col == CW'(IMG_W - 1)) begin
            w_nxt_col = {CW{1'b0}};
            if (w_pos_row == RW'(IMG_H - 1)) begin
                w_nxt_row = {RW{1'b0}};
            end else begin
                w_nxt_row = w_pos_row + RW'(1);
            end
        end else begin
            w_nxt_col = w_pos_col + CW'(1);
            w_nxt_row = w_pos_row;
        end
    end

    // Stage 0: capture pixel and position, advance counters on accepted pixels.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt_col <= {CW{1'b0}};
            r_cnt_row <= {RW{1'b0}};
            r_v0      <= 1'b0;
            r_px0     <= {PW{1'b0}};
            r_col0    <= {CW{1'b0}};
            r_row0    <= {RW{1'b0}};
        end else begin
            r_v0 <= valid;
            if (valid) begin
                r_px0     <= input_act;
                r_col0    <= w_pos_col;
                r_row0    <= w_pos_row;
                r_cnt_col <= w_nxt_col;
                r_cnt_row <= w_nxt_row;
            end
        end
    end

    // Stage 1: shift window left, load new right column, rotate line buffers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_emit1 <= 1'b0;
            for (int i = 0; i < IMG_W; i++) begin
                r_lb0[i] <= {PW{1'b0}};
                r_lb1[i] <= {PW{1'b0}};
            end
            for (int ky = 0; ky < 3; ky++) begin
                for (int kx = 0; kx < 3; kx++) begin
                    r_win[ky][kx] <= {PW{1'b0}};
                end
            end
        end else begin
            r_emit1 <= r_v0 && (r_row0 >= RW'(2)) && (r_col0 >= CW'(2));
            if (r_v0) begin
                for (int ky = 0; ky < 3; ky++) begin
                    r_win[ky][0] <= r_win[ky][1];
                    r_win[ky][1] <= r_win[ky][2];
                end
                r_win[0][2]   <= r_lb1[r_col0];
                r_win[1][2]   <= r_lb0[r_col0];
                r_win[2][2]   <= r_px0;
                r_lb1[r_col0] <= r_lb0[r_col0];
                r_lb0[r_col0] <= r_px0;
            end
        end
    end

    // Per-channel tap gather, MAC and requantization from the current window.
    always_comb begin
        w_q = {PW{1'b0}};
        for (int ch = 0; ch < NCH; ch++) begin
            w_taps[ch] = 72'h0;
            for (int t = 0; t < 9; t++) begin
                w_taps[ch][t*8 +: 8] = r_win[t/3][t%3][ch*8 +: 8];
            end
            w_q[ch*8 +: 8] = requant(mac9(W_DW[ch*72 +: 72], w_taps[ch],
                                          B_DW[ch*8 +: 8]));
        end
    end

    // Stage 2: register result on an emitting window; ready is a 1-cycle strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ready      <= 1'b0;
            output_act <= {PW{1'b0}};
        end else begin
            ready <= r_emit1;
            if (r_emit1) begin
                output_act <= w_q;
            end
        end
    end

endmodule

// File: tb/tb_conv2_dw.sv
// Directed testbench for conv2_dw: constant frames, gaps, tap routing,
// mid-frame sof and mid-frame asynchronous reset.
module tb_conv2_dw;

    localparam logic [575:0] W2 = (576'h40 << 32) | (576'h40 << 72) | (576'h40 << 208);
    localparam logic [63:0]  B2 = 64'h00000000_C8050505;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid;
    logic        sof;
    logic [63:0] act;
    logic [63:0] out1;
    logic [63:0] out2;
    logic        rdy1;
    logic        rdy2;

    int          cyc = 0;
    int          consec = 0;
    logic        prev1 = 1'b0;
    int          pass_cnt = 0;
    int          tot_cnt = 0;
    logic [63:0] q1 [$];
    logic [63:0] q2 [$];
    int          t1 [$];
    int          gaps [8] = '{1, 3, 2, 5, 1, 4, 2, 1};

    conv2_dw dut (
        .clk(clk), .rstn(rstn), .valid(valid), .sof(sof),
        .input_act(act), .output_act(out1), .ready(rdy1)
    );

    conv2_dw #(.W_DW(W2), .B_DW(B2)) dut2 (
        .clk(clk), .rstn(rstn), .valid(valid), .sof(sof),
        .input_act(act), .output_act(out2), .ready(rdy2)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Output collectors, sampled on the falling edge.
    always @(negedge clk) begin
        if (rdy1) begin
            q1.push_back(out1);
            t1.push_back(cyc);
        end
        if (rdy2) q2.push_back(out2);
        if (rdy1 && prev1) consec <= consec + 1;
        prev1 <= rdy1;
    end

    task automatic drive(input logic [63:0] d, input logic s);
        @(negedge clk);
        valid = 1'b1;
        sof   = s;
        act   = d;
        @(posedge clk);
        #1;
        valid = 1'b0;
        sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q1.delete();
        q2.delete();
        t1.delete();
    endtask

    // Sends npix pixels of a constant frame (sof on the first); reports when (2,2) was sampled.
    task automatic send_frame(input logic [63:0] d, input bit use_gaps, input int npix,
                              output int t22);
        t22 = -1;
        for (int i = 0; i < npix; i++) begin
            drive(d, i == 0);
            if (i == 18) t22 = cyc;
            if (use_gaps) idle(gaps[i % 8]);
        end
    endtask

    task automatic test_reset();
        rstn  = 1'b0;
        valid = 1'b0;
        sof   = 1'b0;
        act   = 64'h0;
        #12;
        tot_cnt++; if (rdy1 !== 1'b0) $display("FAIL reset_ready got %b want 0", rdy1); else pass_cnt++;
        tot_cnt++; if (out1 !== 64'h0) $display("FAIL reset_out got %h want 0", out1); else pass_cnt++;
        tot_cnt++; if (rdy2 !== 1'b0) $display("FAIL reset_ready2 got %b want 0", rdy2); else pass_cnt++;
        tot_cnt++; if (out2 !== 64'h0) $display("FAIL reset_out2 got %h want 0", out2); else pass_cnt++;
        @(negedge clk);
        rstn = 1'b1;
        idle(2);
    endtask

    task automatic test_const_frames();
        logic [63:0] din [4];
        logic [63:0] exp [4];
        int t22;
        din[0] = 64'h40404040_40404040; exp[0] = 64'h48484848_48484848;
        din[1] = 64'h7F7F7F7F_7F7F7F7F; exp[1] = 64'h7F7F7F7F_7F7F7F7F;
        din[2] = 64'hC0C0C0C0_C0C0C0C0; exp[2] = 64'h00000000_00000000;
        din[3] = 64'h10C07F40_10C07F40; exp[3] = 64'h12007F48_12007F48;
        for (int f = 0; f < 4; f++) begin
            clear_q();
            send_frame(din[f], 1'b0, 64, t22);
            idle(4);
            tot_cnt++;
            if (q1.size() !== 36) $display("FAIL const%0d_count got %0d want 36", f, q1.size());
            else pass_cnt++;
            tot_cnt++;
            if (t1.size() == 0 || t1[0] !== t22 + 2)
                $display("FAIL const%0d_latency got %0d want %0d", f, (t1.size() == 0) ? -1 : t1[0], t22 + 2);
            else pass_cnt++;
            foreach (q1[k]) begin
                tot_cnt++;
                if (q1[k] !== exp[f]) $display("FAIL const%0d_val[%0d] got %h want %h", f, k, q1[k], exp[f]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_gaps();
        int t22;
        int c0;
        c0 = consec;
        clear_q();
        send_frame(64'h40404040_40404040, 1'b1, 64, t22);
        idle(4);
        tot_cnt++;
        if (q1.size() !== 36) $display("FAIL gaps_count got %0d want 36", q1.size()); else pass_cnt++;
        foreach (q1[k]) begin
            tot_cnt++;
            if (q1[k] !== 64'h48484848_48484848) $display("FAIL gaps_val[%0d] got %h want 4848484848484848", k, q1[k]);
            else pass_cnt++;
        end
        tot_cnt++;
        if (consec !== c0) $display("FAIL gaps_consecutive_ready got %0d want %0d", consec, c0); else pass_cnt++;
    endtask

    task automatic test_routing();
        logic [7:0]  p8;
        logic [63:0] e;
        int          k;
        clear_q();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                p8 = 8'(r * 8 + c);
                drive({8{p8}}, (r == 0) && (c == 0));
            end
        end
        idle(4);
        tot_cnt++;
        if (q2.size() !== 36) $display("FAIL route_count got %0d want 36", q2.size()); else pass_cnt++;
        k = 0;
        for (int r = 2; r < 8; r++) begin
            for (int c = 2; c < 8; c++) begin
                e = 64'h0;
                e[7:0]   = 8'((((r - 1) * 8) + c - 1) >> 1);
                e[15:8]  = 8'((((r - 2) * 8) + c - 2) >> 1);
                e[23:16] = 8'(((r * 8) + c) >> 1);
                e[31:24] = 8'h01;
                tot_cnt++;
                if (k >= q2.size()) $display("FAIL route_val(%0d,%0d) got none want %h", r, c, e);
                else if (q2[k] !== e) $display("FAIL route_val(%0d,%0d) got %h want %h", r, c, q2[k], e);
                else pass_cnt++;
                k++;
            end
        end
    endtask

    task automatic test_sof_mid();
        int t22;
        int dummy;
        send_frame(64'h7F7F7F7F_7F7F7F7F, 1'b0, 28, dummy);
        idle(4);
        clear_q();
        send_frame(64'h40404040_40404040, 1'b0, 64, t22);
        idle(4);
        tot_cnt++;
        if (q1.size() !== 36) $display("FAIL sof_count got %0d want 36", q1.size()); else pass_cnt++;
        tot_cnt++;
        if (t1.size() == 0 || t1[0] !== t22 + 2)
            $display("FAIL sof_first_pulse got %0d want %0d", (t1.size() == 0) ? -1 : t1[0], t22 + 2);
        else pass_cnt++;
        foreach (q1[k]) begin
            tot_cnt++;
            if (q1[k] !== 64'h48484848_48484848) $display("FAIL sof_val[%0d] got %h want 4848484848484848", k, q1[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int t22;
        send_frame(64'h40404040_40404040, 1'b0, 30, t22);
        tot_cnt++;
        if (rdy1 !== 1'b1) $display("FAIL rstmid_pre_ready got %b want 1", rdy1); else pass_cnt++;
        tot_cnt++;
        if (out1 !== 64'h48484848_48484848) $display("FAIL rstmid_pre_out got %h want 4848484848484848", out1);
        else pass_cnt++;
        #1;
        rstn = 1'b0;
        #1;
        tot_cnt++; if (rdy1 !== 1'b0) $display("FAIL rstmid_ready got %b want 0", rdy1); else pass_cnt++;
        tot_cnt++; if (out1 !== 64'h0) $display("FAIL rstmid_out got %h want 0", out1); else pass_cnt++;
        @(negedge clk);
        rstn = 1'b1;
        idle(2);
        clear_q();
        // First pixel without sof: reset alone must restart at (0,0).
        for (int i = 0; i < 64; i++) begin
            drive(64'h40404040_40404040, 1'b0);
            if (i == 18) t22 = cyc;
        end
        idle(4);
        tot_cnt++;
        if (q1.size() !== 36) $display("FAIL rstmid_count got %0d want 36", q1.size()); else pass_cnt++;
        tot_cnt++;
        if (t1.size() == 0 || t1[0] !== t22 + 2)
            $display("FAIL rstmid_first_pulse got %0d want %0d", (t1.size() == 0) ? -1 : t1[0], t22 + 2);
        else pass_cnt++;
        foreach (q1[k]) begin
            tot_cnt++;
            if (q1[k] !== 64'h48484848_48484848) $display("FAIL rstmid_val[%0d] got %h want 4848484848484848", k, q1[k]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_const_frames();
        test_gaps();
        test_routing();
        test_sof_mid();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
